// File: rtl/fare_gate_ctrl.sv
// fare_gate_ctrl -- ticket-barrier controller.
//
// A card tap (nfc) samples card_valid / monthly / balance. The card is then
// checked for one cycle:
//   * invalid cards and stored-value cards below FARE show a message
//   * monthly passes open the gate straight away
//   * stored-value cards with enough money first raise a debit request, and
//     the gate opens once the back office accepts it.
// The gate closes on a rising edge of pass_sensor or after OPEN_CYC cycles,
// whichever comes first. A maintenance request puts the gate in service mode.
//
// Optional build macro: TAILGATE_DETECT_EN. When it is defined, a rising
// pass_sensor edge while idle raises an ALARM for MSG_CYC cycles.
//
// Parameters:
//   BAL_W    balance / fare width in bits (4..32)
//   FARE     fare deducted per stored-value entry
//   OPEN_CYC maximum gate-open cycles (>= 2)
//   MSG_CYC  message hold cycles (>= 1)
// Ports:
//   clk          clock; every state update happens on its rising edge
//   rst          asynchronous active-low reset
//   nfc          card-tap strobe
//   card_valid   card account exists (sampled with nfc)
//   monthly      card is a monthly pass (sampled with nfc)
//   balance      stored-value balance (sampled with nfc)
//   maintenance  service-mode request
//   pass_sensor  passenger-through beam (level)
//   debit_ready  back office accepts the debit
//   debit_valid  debit request pending
//   debit_bal    balance after the fare is deducted, valid with debit_valid
//   open         gate actuator
//   disp         000 idle, 001 no funds, 010 invalid, 100 open/balance,
//                101 open/monthly, 111 service
//   sound        00 silent, 01 error, 10 pass, 11 alarm
// Every output is a flop, so no path runs straight from an input to an output.
module fare_gate_ctrl #(
  parameter int BAL_W    = 16,
  parameter int FARE     = 325,
  parameter int OPEN_CYC = 8,
  parameter int MSG_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nfc,
  input  logic             card_valid,
  input  logic             monthly,
  input  logic [BAL_W-1:0] balance,
  input  logic             maintenance,
  input  logic             pass_sensor,
  input  logic             debit_ready,
  output logic             debit_valid,
  output logic [BAL_W-1:0] debit_bal,
  output logic             open,
  output logic [2:0]       disp,
  output logic [1:0]       sound
);

  localparam int MAX_CYC = (OPEN_CYC > MSG_CYC) ? OPEN_CYC : MSG_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] MSG_LOAD  = CNT_W'(MSG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BAL_W-1:0] FARE_V    = BAL_W'(FARE);

`ifdef TAILGATE_DETECT_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_DEBIT  = 3'd2,
    S_OPEN   = 3'd3,
    S_MSG    = 3'd4,
    S_SERV   = 3'd5,
    S_SERV_E = 3'd6,
    S_ALARM  = 3'd7
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_DEBIT  = 3'd2,
    S_OPEN   = 3'd3,
    S_MSG    = 3'd4,
    S_SERV   = 3'd5,
    S_SERV_E = 3'd6
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sens_q;
  logic             cv_q, mon_q;
  logic [BAL_W-1:0] bal_q;
  logic             open_q, open_d;
  logic             dv_q, dv_d;
  logic [BAL_W-1:0] dbal_q, dbal_d;
  logic [2:0]       disp_q, disp_d;
  logic [1:0]       sound_q, sound_d;
  logic             sens_rise_s;
  logic             smp_load_s;

  // The edge is measured against the previous-cycle flop, so a sensor that
  // is already high when the gate opens must fall and rise again to count.
  assign sens_rise_s = pass_sensor & ~sens_q;
  // Maintenance outranks a tap in IDLE, so a tap only samples when it wins.
  assign smp_load_s  = (state_q == S_IDLE) & ~maintenance & nfc;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and hold/open counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (maintenance) begin
          state_d = S_SERV;
        end else if (nfc) begin
          state_d = S_CHECK;
        end else begin
`ifdef TAILGATE_DETECT_EN
          if (sens_rise_s) begin
            state_d = S_ALARM;
            cnt_d   = MSG_LOAD;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_CHECK: begin
        if (!cv_q) begin
          state_d = S_MSG;
          cnt_d   = MSG_LOAD;
        end else if (mon_q) begin
          state_d = S_OPEN;
          cnt_d   = OPEN_LOAD;
        end else if (bal_q >= FARE_V) begin
          state_d = S_DEBIT;
        end else begin
          state_d = S_MSG;
          cnt_d   = MSG_LOAD;
        end
      end
      S_DEBIT: begin
        if (debit_ready) begin
          state_d = S_OPEN;
          cnt_d   = OPEN_LOAD;
        end else begin
          state_d = S_DEBIT;
        end
      end
      S_OPEN: begin
        if (sens_rise_s || (cnt_q == CNT_ZERO)) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_MSG: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_SERV: begin
        if (nfc) begin
          state_d = S_SERV_E;
        end else if (!maintenance) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SERV;
        end
      end
      S_SERV_E: begin
        state_d = S_SERV;
      end
`ifdef TAILGATE_DETECT_EN
      S_ALARM: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode for the next cycle. Outputs are registered from state_d,
  // so they line up with the state they describe.
  always_comb begin
    open_d  = (state_d == S_OPEN);
    dv_d    = (state_d == S_DEBIT);
    dbal_d  = {BAL_W{1'b0}};
    disp_d  = 3'b000;
    sound_d = 2'b00;
    if (dv_d) begin
      // bal_q >= FARE was checked before DEBIT is entered, so this cannot underflow.
      dbal_d = bal_q - FARE_V;
    end else begin
      dbal_d = {BAL_W{1'b0}};
    end
    case (state_d)
      S_OPEN:   disp_d = mon_q ? 3'b101 : 3'b100;
      S_MSG:    disp_d = cv_q ? 3'b001 : 3'b010;
      S_SERV:   disp_d = 3'b111;
      S_SERV_E: disp_d = 3'b111;
`ifdef TAILGATE_DETECT_EN
      S_ALARM:  disp_d = 3'b010;
`endif
      default:  disp_d = 3'b000;
    endcase
    if ((state_d == S_OPEN) && (state_q != S_OPEN)) begin
      sound_d = 2'b10;
    end else if ((state_d == S_MSG) && (state_q != S_MSG)) begin
      sound_d = 2'b01;
    end else if (state_d == S_SERV_E) begin
      sound_d = 2'b01;
`ifdef TAILGATE_DETECT_EN
    end else if (state_d == S_ALARM) begin
      sound_d = 2'b11;
`endif
    end else begin
      sound_d = 2'b00;
    end
  end

  // Counter, sensor history, tap samples and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= CNT_ZERO;
      sens_q  <= 1'b0;
      cv_q    <= 1'b0;
      mon_q   <= 1'b0;
      bal_q   <= {BAL_W{1'b0}};
      open_q  <= 1'b0;
      dv_q    <= 1'b0;
      dbal_q  <= {BAL_W{1'b0}};
      disp_q  <= 3'b000;
      sound_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      sens_q  <= pass_sensor;
      if (smp_load_s) begin
        cv_q  <= card_valid;
        mon_q <= monthly;
        bal_q <= balance;
      end
      open_q  <= open_d;
      dv_q    <= dv_d;
      dbal_q  <= dbal_d;
      disp_q  <= disp_d;
      sound_q <= sound_d;
    end
  end

  assign open        = open_q;
  assign debit_valid = dv_q;
  assign debit_bal   = dbal_q;
  assign disp        = disp_q;
  assign sound       = sound_q;

endmodule
